// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the MIPS core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives
// the shared ALU, register file, PC mux and unified memory port, and stalls
// on mem_ready.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   op, funct          - instruction fields from the instruction register
//   zero               - ALU zero flag (branch resolution in EXEC)
//   mem_ready          - memory completed the current access this cycle
//   mem_re/mem_we      - memory read / write request
//   mem_sel            - memory address source (0 = PC, 1 = ALU)
//   ir_we, pc_we       - instruction register / PC load enables
//   pc_next            - PC source (PC+4, jump, rs, branch)
//   reg_dst, reg_in    - register write select / write data source
//   reg_we             - register file write enable
//   alu_src, alu_ctrl  - ALU B operand select / ALU operation
//   state              - current FSM state (debug)
//   illegal            - undecodable instruction flag
//   instr_count        - retired-instruction counter
//
// Build option: define MULTICYCLE_ILLEGAL_TRAP_EN to halt on an illegal
// instruction (sticky flag). Otherwise illegal instructions retire as NOPs.
module multicycle_ctrl #(
    parameter int unsigned CNT_W    = 32,
    parameter logic [5:0]  JR_FUNCT = 6'b001000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_re,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_next,
    output logic [1:0]       reg_dst,
    output logic             alu_src,
    output logic [1:0]       alu_ctrl,
    output logic             reg_we,
    output logic [1:0]       reg_in,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t     cur, nxt;
    logic [5:0] op_q, funct_q;
    logic       legal;
    logic [1:0] r_alu;

    // Legality is judged on the live fields, since op_q is loaded in DECODE.
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                              (funct == FN_SLT) || (funct == JR_FUNCT);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_XORI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        r_alu = 2'd0;
        case (funct_q)
            FN_SUB:  r_alu = 2'd1;
            FN_SLT:  r_alu = 2'd3;
            default: r_alu = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= FETCH;
            op_q        <= '0;
            funct_q     <= '0;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE) begin
                op_q    <= op;
                funct_q <= funct;
            end
            if (pc_we)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal_q <= 1'b0;
        else if (cur == DECODE && !legal)
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = (cur == DECODE) && !legal;
`endif

    always_comb begin
        nxt      = cur;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        mem_sel  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_next  = 2'd0;
        reg_dst  = 2'd0;
        alu_src  = 1'b0;
        alu_ctrl = 2'd0;
        reg_we   = 1'b0;
        reg_in   = 2'd0;
        case (cur)
            FETCH: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    nxt   = DECODE;
                end
            end
            DECODE: begin
                if (legal) begin
                    nxt = EXEC;
                end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    nxt = HALT;
`else
                    pc_we = 1'b1;
                    nxt   = FETCH;
`endif
                end
            end
            EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        if (funct_q == JR_FUNCT) begin
                            pc_we   = 1'b1;
                            pc_next = 2'd2;
                            nxt     = FETCH;
                        end else begin
                            alu_src  = 1'b1;
                            alu_ctrl = r_alu;
                            nxt      = WB;
                        end
                    end
                    OP_XORI: begin
                        alu_ctrl = 2'd2;
                        nxt      = WB;
                    end
                    OP_LW, OP_SW: nxt = MEM;
                    OP_J: begin
                        pc_we   = 1'b1;
                        pc_next = 2'd1;
                        nxt     = FETCH;
                    end
                    OP_JAL: begin
                        pc_we   = 1'b1;
                        pc_next = 2'd1;
                        reg_we  = 1'b1;
                        reg_dst = 2'd2;
                        reg_in  = 2'd2;
                        nxt     = FETCH;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_src  = 1'b1;
                        alu_ctrl = 2'd1;
                        pc_we    = 1'b1;
                        // Branch taken when zero matches the beq sense.
                        pc_next  = ((op_q == OP_BEQ) == zero) ? 2'd3 : 2'd0;
                        nxt      = FETCH;
                    end
                    default: nxt = FETCH;
                endcase
            end
            MEM: begin
                mem_sel = 1'b1;
                mem_re  = (op_q == OP_LW);
                mem_we  = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_SW) begin
                        pc_we = 1'b1;
                        nxt   = FETCH;
                    end else begin
                        nxt = WB;
                    end
                end
            end
            WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                nxt    = FETCH;
                case (op_q)
                    OP_RTYPE: begin
                        reg_dst  = 2'd1;
                        alu_src  = 1'b1;
                        alu_ctrl = r_alu;
                    end
                    OP_XORI: alu_ctrl = 2'd2;
                    OP_LW:   reg_in   = 2'd1;
                    default: ;
                endcase
            end
            HALT: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                nxt = HALT;
`else
                nxt = FETCH;
`endif
            end
            default: nxt = FETCH;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks add, lw (with memory stall),
// beq/bne, jal, jr, an illegal opcode and an sw interrupted by reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        mem_re, mem_we, mem_sel, ir_we, pc_we;
    logic [1:0]  pc_next, reg_dst, alu_ctrl, reg_in;
    logic        alu_src, reg_we, illegal;
    logic [2:0]  state;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32), .JR_FUNCT(6'b001000)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_re(mem_re), .mem_we(mem_we),
        .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_next(pc_next),
        .reg_dst(reg_dst), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
        .reg_we(reg_we), .reg_in(reg_in), .state(state), .illegal(illegal),
        .instr_count(instr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        #2;
        check("rst_state", 32'(state), 0);
        check("rst_mem_re", 32'(mem_re), 1);
        check("rst_mem_sel", 32'(mem_sel), 0);
        check("rst_pc_we", 32'(pc_we), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_count", instr_count, 0);
        tick(); tick();
        reset = 1'b0;
        op = 6'h00; funct = 6'h20;
        #1;
        check("fetch_ir_we", 32'(ir_we), 1);

        // add: 0,1,2,4,0
        tick(); check("add_dec", 32'(state), 1);
        check("add_dec_regwe", 32'(reg_we), 0);
        tick(); check("add_exec", 32'(state), 2);
        check("add_exec_alu", 32'(alu_ctrl), 0);
        check("add_exec_src", 32'(alu_src), 1);
        check("add_exec_regwe", 32'(reg_we), 0);
        tick(); check("add_wb", 32'(state), 4);
        check("add_wb_regwe", 32'(reg_we), 1);
        check("add_wb_dst", 32'(reg_dst), 1);
        check("add_wb_pcwe", 32'(pc_we), 1);
        tick(); check("add_fetch", 32'(state), 0);
        check("add_count", instr_count, 1);

        // lw with two stalled MEM cycles
        op = 6'h23;
        tick(); tick();
        check("lw_exec", 32'(state), 2);
        check("lw_exec_src", 32'(alu_src), 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lw_mem_state", 32'(state), 3);
            check("lw_mem_re", 32'(mem_re), 1);
            check("lw_mem_sel", 32'(mem_sel), 1);
            check("lw_mem_we", 32'(mem_we), 0);
            check("lw_mem_pcwe", 32'(pc_we), 0);
        end
        mem_ready = 1'b1;
        tick(); check("lw_wb", 32'(state), 4);
        check("lw_wb_in", 32'(reg_in), 1);
        check("lw_wb_dst", 32'(reg_dst), 0);
        check("lw_wb_regwe", 32'(reg_we), 1);
        tick(); check("lw_fetch", 32'(state), 0);
        check("lw_count", instr_count, 2);

        // beq
        op = 6'h04; zero = 1'b1;
        tick(); tick();
        check("beq_exec", 32'(state), 2);
        check("beq_taken", 32'(pc_next), 3);
        check("beq_pcwe", 32'(pc_we), 1);
        zero = 1'b0; #1;
        check("beq_not_taken", 32'(pc_next), 0);
        tick(); check("beq_fetch", 32'(state), 0);
        check("beq_count", instr_count, 3);

        // bne
        op = 6'h05; zero = 1'b1;
        tick(); tick();
        check("bne_not_taken", 32'(pc_next), 0);
        check("bne_pcwe", 32'(pc_we), 1);
        zero = 1'b0; #1;
        check("bne_taken", 32'(pc_next), 3);
        tick(); check("bne_count", instr_count, 4);

        // jal
        op = 6'h03;
        tick(); tick();
        check("jal_pcwe", 32'(pc_we), 1);
        check("jal_pcnext", 32'(pc_next), 1);
        check("jal_regwe", 32'(reg_we), 1);
        check("jal_dst", 32'(reg_dst), 2);
        check("jal_in", 32'(reg_in), 2);
        tick(); check("jal_fetch", 32'(state), 0);
        check("jal_count", instr_count, 5);

        // jr
        op = 6'h00; funct = 6'h08;
        tick(); tick();
        check("jr_pcnext", 32'(pc_next), 2);
        check("jr_regwe", 32'(reg_we), 0);
        check("jr_pcwe", 32'(pc_we), 1);
        tick(); check("jr_count", instr_count, 6);

        // illegal opcode
        op = 6'h3F;
        tick(); check("ill_dec", 32'(state), 1);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        check("ill_dec_pcwe", 32'(pc_we), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ill_halt", 32'(state), 5);
            check("ill_flag", 32'(illegal), 1);
            check("ill_pcwe", 32'(pc_we), 0);
            check("ill_count", instr_count, 6);
        end
`else
        check("ill_pulse", 32'(illegal), 1);
        check("ill_pcwe", 32'(pc_we), 1);
        check("ill_pcnext", 32'(pc_next), 0);
        tick();
        check("ill_fetch", 32'(state), 0);
        check("ill_clear", 32'(illegal), 0);
        check("ill_count", instr_count, 7);
`endif

        // sw interrupted by reset in MEM
        reset = 1'b1; #2;
        check("rst2_state", 32'(state), 0);
        check("rst2_count", instr_count, 0);
        check("rst2_illegal", 32'(illegal), 0);
        reset = 1'b0;
        op = 6'h2B; mem_ready = 1'b0;
        tick(); check("fetch_hold", 32'(state), 0);
        check("fetch_hold_irwe", 32'(ir_we), 0);
        mem_ready = 1'b1;
        tick(); tick();
        check("sw_exec", 32'(state), 2);
        mem_ready = 1'b0;
        tick(); check("sw_mem", 32'(state), 3);
        check("sw_mem_we", 32'(mem_we), 1);
        check("sw_mem_re", 32'(mem_re), 0);
        check("sw_mem_sel", 32'(mem_sel), 1);
        #2 reset = 1'b1;
        #1;
        check("sw_rst_we", 32'(mem_we), 0);
        check("sw_rst_state", 32'(state), 0);
        check("sw_rst_count", instr_count, 0);
        tick();
        reset = 1'b0; mem_ready = 1'b1; #1;
        check("post_rst_state", 32'(state), 0);
        check("post_rst_re", 32'(mem_re), 1);
        tick(); check("post_rst_dec", 32'(state), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS CPU. It replaces single-cycle decode with an FSM that steps one instruction through FETCH, DECODE, EXEC, MEM and WB.
- It drives the shared ALU, register file, PC mux and single unified memory port, and stalls on a memory ready handshake.
- Supports the same ISA subset as the single-cycle core: add, sub, slt, jr, lw, sw, j, jal, beq, bne, xori.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- JR_FUNCT, 6'b001000, funct code treated as jr.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  opcode field from instruction register; valid from DECODE onward
- funct  in  6  funct field from instruction register
- zero  in  1  ALU zero flag, combinational from the datapath
- mem_ready  in  1  memory has completed the current read/write this cycle
- mem_re  out  1  memory read request (fetch or lw)
- mem_we  out  1  memory write request (sw)
- mem_sel  out  1  memory address source: 0 = PC, 1 = ALU result
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC; one-cycle pulse per retired instruction
- pc_next  out  2  PC source: 0 = PC+4, 1 = jump target, 2 = rs, 3 = branch target
- reg_dst  out  2  write register select: 0 = rt, 1 = rd, 2 = $31
- alu_src  out  1  ALU B operand: 0 = immediate, 1 = rt
- alu_ctrl  out  2  ALU op: 0 = add, 1 = sub, 2 = xor, 3 = slt
- reg_we  out  1  register file write enable
- reg_in  out  2  write data source: 0 = ALU, 1 = memory, 2 = PC+4
- state  out  3  current FSM state, for debug
- illegal  out  1  undecodable instruction flag
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5.
- Reset (asynchronous): state = FETCH, op_q/funct_q = 0, instr_count = 0, illegal = 0. All outputs take their FETCH values below.
- Outputs are Moore on state plus the latched op_q/funct_q. Exception: pc_next in EXEC for a branch also depends on zero.
- Any output not listed for a state is 0. No X values are driven.
- FETCH:
  - mem_re = 1, mem_sel = 0.
  - Hold while mem_ready = 0.
  - On mem_ready = 1: ir_we = 1 that cycle, next state = DECODE.
- DECODE:
  - Latch op/funct into op_q/funct_q.
  - Legal opcode: next state = EXEC.
  - Illegal opcode or R-type with unknown funct: handled per ILLEGAL_TRAP_EN.
- EXEC:
  - add/sub/slt: alu_src = 1, alu_ctrl = 0/1/3; next state = WB.
  - xori: alu_src = 0, alu_ctrl = 2; next state = WB.
  - lw/sw: alu_src = 0, alu_ctrl = 0; next state = MEM.
  - j: pc_we = 1, pc_next = 1; next state = FETCH.
  - jal: as j, plus reg_we = 1, reg_dst = 2, reg_in = 2.
  - jr: pc_we = 1, pc_next = 2; next state = FETCH.
  - beq: alu_src = 1, alu_ctrl = 1, pc_we = 1, pc_next = zero ? 3 : 0; next state = FETCH.
  - bne: same as beq with pc_next = zero ? 0 : 3.
- MEM:
  - mem_sel = 1, alu_ctrl = 0, alu_src = 0.
  - mem_re = 1 for lw, mem_we = 1 for sw; held constant until mem_ready.
  - lw on ready: next state = WB.
  - sw on ready: pc_we = 1, pc_next = 0; next state = FETCH.
- WB:
  - reg_we = 1 and pc_we = 1, pc_next = 0; next state = FETCH.
  - R-type: reg_dst = 1, reg_in = 0, alu_src = 1, alu_ctrl held from EXEC.
  - xori: reg_dst = 0, reg_in = 0, alu_ctrl = 2.
  - lw: reg_dst = 0, reg_in = 1.
- Latency with mem_ready tied high:
  - R-type and xori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - j, jal, jr, beq, bne: 3 cycles.
  - Each cycle with mem_ready = 0 in FETCH or MEM adds exactly one cycle.
- instr_count increments on every pc_we pulse and wraps modulo 2^CNT_W.
- mem_re and mem_we are never both 1. pc_we is exactly one pulse per instruction.
- Reset asserted mid-MEM with mem_we = 1: mem_we drops asynchronously; the instruction does not retire and the count is unchanged.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction in DECODE goes to HALT.
  - illegal = 1, sticky.
  - All enables 0, no pc_we.
  - Remains in HALT until reset.
- Undefined: an illegal instruction is a NOP.
  - In DECODE: pc_we = 1, pc_next = 0, instr_count increments; next state = FETCH.
  - illegal pulses 1 for that DECODE cycle only.
  - HALT is unreachable.

Test Plan:
- add ($op = 0, funct = 0x20$), mem_ready = 1: states 0,1,2,4,0. alu_ctrl = 0 in EXEC. reg_we = 1, reg_dst = 1 in WB only. instr_count 0 -> 1.
- lw (op = 0x23) with mem_ready low for 2 cycles in MEM: mem_re = 1 and mem_sel = 1 held for 3 MEM cycles, then WB with reg_in = 1, reg_dst = 0. Total 7 cycles.
- beq (op = 0x04): zero = 1 gives pc_next = 3, pc_we = 1 in EXEC. zero = 0 gives pc_next = 0. bne (0x05) gives the inverse.
- jal (op = 0x03): in EXEC, pc_we = 1, pc_next = 1, reg_we = 1, reg_dst = 2, reg_in = 2. jr (funct = 0x08): pc_next = 2, reg_we = 0.
- op = 0x3F: with the macro defined, state = 5, illegal = 1 held for 10 cycles, instr_count unchanged. Without it, one illegal pulse, count +1, back to FETCH.
- sw (0x2B) with reset asserted in MEM while mem_we = 1: mem_we, state and instr_count are 0 immediately, before the next clock edge. After release, FETCH with mem_re = 1.
